// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shift_add_multiplier_pkg                                         |
// | Shared state encoding and sizing for the multiplier and Adder.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package shift_add_multiplier_pkg;

  localparam int MULT_WIDTH   = 16;
  localparam int MULT_COUNT_W = 5;
  localparam int MULT_ITERS   = MULT_WIDTH;

  // 2'd3 is not a legal state; the controller steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } multState_t;

endpackage
`default_nettype wire

// File: rtl/Adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Adder                                                            |
// | Combinational 16-bit adder with carry-out in Soma[16].           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module Adder
  import shift_add_multiplier_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] OperandoA,
  input  logic [MULT_WIDTH-1:0] OperandoB,
  output logic [MULT_WIDTH:0]   Soma
);

  assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shift_add_multiplier                                             |
// | Sequential 16x16 unsigned shift-add multiplier, 16 iterations.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH   = MULT_WIDTH,
  parameter int COUNT_W = MULT_COUNT_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicando,
  input  logic [WIDTH-1:0]   Multiplicador,
  output logic [2*WIDTH-1:0] Produto,
  output logic               Busy,
  output logic               Done
);

  localparam logic [COUNT_W-1:0] c_lastIter = COUNT_W'(MULT_ITERS - 1);

  multState_t           r_state;
  multState_t           w_nextState;
  logic [WIDTH-1:0]     r_regA;
  logic [2*WIDTH:0]     r_acc;
  logic [COUNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0]   r_produto;
  logic [WIDTH-1:0]     w_operandoA;
  logic [WIDTH-1:0]     w_operandoB;
  logic [WIDTH:0]       w_soma;
  logic                 w_lastIter;
  logic                 w_unusedAccTop;

  assign w_operandoA = r_acc[2*WIDTH-1:WIDTH];
  assign w_operandoB = r_acc[0] ? r_regA : '0;
  assign w_lastIter  = (r_count == c_lastIter);
  // Acc[32] is always shifted in as zero; the carry lives in Acc[31].
  assign w_unusedAccTop = r_acc[2*WIDTH];

  Adder u_adder (
    .OperandoA (w_operandoA),
    .OperandoB (w_operandoB),
    .Soma      (w_soma)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = Start ? RUN : IDLE;
      RUN:     w_nextState = w_lastIter ? DONE : RUN;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_regA    <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_produto <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_regA  <= Multiplicando;
            r_acc   <= {{(WIDTH + 1){1'b0}}, Multiplicador};
            r_count <= '0;
          end
        end
        RUN: begin
          r_acc   <= {1'b0, w_soma, r_acc[WIDTH-1:1]};
          r_count <= r_count + COUNT_W'(1);
          if (w_lastIter) begin
            r_produto <= {w_soma, r_acc[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Produto = r_produto;
  assign Busy    = (r_state == RUN) || (r_state == DONE);
  assign Done    = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_shift_add_multiplier                                          |
// | Directed plus randomized checks against an A*B reference model.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_shift_add_multiplier;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] Multiplicando;
  logic [15:0] Multiplicador;
  logic [31:0] Produto;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [31:0] lastProd;
  logic [15:0] va [200];
  logic [15:0] vb [200];

  shift_add_multiplier dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .Multiplicando (Multiplicando),
    .Multiplicador (Multiplicador),
    .Produto       (Produto),
    .Busy          (Busy),
    .Done          (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refMul(input logic [15:0] a, input logic [15:0] b);
    return {16'h0, a} * {16'h0, b};
  endfunction

  // One full operation from IDLE: latency, held result, product and return to IDLE.
  task automatic doOp(input logic [15:0] a, input logic [15:0] b, input string tag);
    Multiplicando = a;
    Multiplicador = b;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    Multiplicando = 16'($urandom);
    Multiplicador = 16'($urandom);
    cyc = 1;
    check({tag, " busy"}, {31'h0, Busy}, 32'd1);
    check({tag, " held"}, Produto, lastProd);
    while (!Done && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check({tag, " done"}, {31'h0, Done}, 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'd17);
    check({tag, " product"}, Produto, refMul(a, b));
    lastProd = refMul(a, b);
    @(posedge Clk); #1;
    check({tag, " idle busy"}, {31'h0, Busy}, 32'd0);
    check({tag, " idle done"}, {31'h0, Done}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Multiplicando = 16'h0;
    Multiplicador = 16'h0;
    lastProd = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset busy", {31'h0, Busy}, 32'd0);
    check("reset done", {31'h0, Done}, 32'd0);
    check("reset produto", Produto, 32'h0);
    Reset = 1'b0;

    doOp(16'd3, 16'd5, "3x5");
    doOp(16'hFFFF, 16'hFFFF, "ffffxffff");
    check("ffff const", Produto, 32'hFFFE0001);
    doOp(16'd8, 16'd8, "8x8");
    doOp(16'h0000, 16'h1234, "0x1234");
    doOp(16'h1234, 16'h0000, "1234x0");

    // Start held high across RUN/DONE with operands swapped mid-run.
    Multiplicando = 16'd11;
    Multiplicador = 16'd13;
    Start = 1'b1;
    @(posedge Clk); #1;
    cyc = 1;
    Multiplicando = 16'd7;
    Multiplicador = 16'd7;
    while (!Done && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 30) Start = 1'b0;
    end
    check("held first latency", 32'(cyc), 32'd17);
    check("held first product", Produto, refMul(16'd11, 16'd13));
    @(posedge Clk); #1;
    cyc++;
    check("held pulse width", {31'h0, Done}, 32'd0);
    check("held idle busy", {31'h0, Busy}, 32'd0);
    while (!Done && cyc < 60) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 30) Start = 1'b0;
    end
    check("held second latency", 32'(cyc), 32'd35);
    check("held second product", Produto, 32'h31);
    @(posedge Clk); #1;
    check("held second pulse", {31'h0, Done}, 32'd0);
    check("held second busy", {31'h0, Busy}, 32'd0);
    lastProd = 32'h31;

    // Reset in the middle of an operation.
    Multiplicando = 16'h00FF;
    Multiplicador = 16'h0101;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    check("midrun busy", {31'h0, Busy}, 32'd1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("midreset busy", {31'h0, Busy}, 32'd0);
    check("midreset done", {31'h0, Done}, 32'd0);
    check("midreset produto", Produto, 32'h0);
    lastProd = 32'h0;
    doOp(16'h00FF, 16'h0101, "ffx101");
    check("ffx101 const", Produto, 32'h0000FFFF);

    // Randomized-order sweep including two directed corners.
    va[0] = 16'h8000; vb[0] = 16'h0002;
    va[1] = 16'h0001; vb[1] = 16'hFFFF;
    for (int i = 2; i < 200; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
    end
    for (int i = 199; i > 0; i--) begin
      int j;
      logic [15:0] ta;
      logic [15:0] tb;
      j = int'($urandom_range(i, 0));
      ta = va[i]; va[i] = va[j]; va[j] = ta;
      tb = vb[i]; vb[i] = vb[j]; vb[j] = tb;
    end
    for (int i = 0; i < 200; i++) begin
      doOp(va[i], vb[i], $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
